issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler.sv | 161 ++++++++++++++++
 tb/tb_issue_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: tracks source readiness per slot, wakes sources on
// writeback broadcast and issues the oldest ready slot through a one-entry issue register.
module issue_scheduler #(
    parameter int IQ_SIZE = 8,
    parameter int PHYS_W  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [PHYS_W-1:0]          alloc_rs,
    input  logic [PHYS_W-1:0]          alloc_rt,
    input  logic                       alloc_uses_rs,
    input  logic                       alloc_uses_rt,
    input  logic                       alloc_rs_rdy,
    input  logic                       alloc_rt_rdy,
    output logic                       alloc_ready,
    output logic [$clog2(IQ_SIZE)-1:0] alloc_slot,
    input  logic                       wb_valid,
    input  logic [PHYS_W-1:0]          wb_tag,
    output logic                       issue_valid,
    output logic [$clog2(IQ_SIZE)-1:0] issue_slot,
    input  logic                       issue_ready,
    output logic [$clog2(IQ_SIZE):0]   occupancy
);

    localparam int IDX_W = $clog2(IQ_SIZE);

    logic [IQ_SIZE-1:0]             valid_q, valid_d;
    logic [IQ_SIZE-1:0]             rs_rdy_q, rs_rdy_d;
    logic [IQ_SIZE-1:0]             rt_rdy_q, rt_rdy_d;
    logic [IQ_SIZE-1:0][PHYS_W-1:0] rs_tag_q, rs_tag_d;
    logic [IQ_SIZE-1:0][PHYS_W-1:0] rt_tag_q, rt_tag_d;
    // older_q[i][j] set means slot i was allocated before slot j
    logic [IQ_SIZE-1:0][IQ_SIZE-1:0] older_q, older_d;
    logic                           issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]               issue_slot_q, issue_slot_d;
    logic [IDX_W:0]                 occ_q, occ_d;

    logic [IQ_SIZE-1:0] eligible;
    logic [IQ_SIZE-1:0] pick;
    logic               any_elig;
    logic [IDX_W-1:0]   pick_idx;
    logic               alloc_fire;
    logic               issue_fire;
    logic               can_load;

    always_comb begin
        alloc_ready = ~&valid_q;
        alloc_slot  = '0;
        for (int i = IQ_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_slot = IDX_W'(i);
        end
    end

    // A slot wins selection when no other eligible slot is older than it.
    always_comb begin
        eligible = '0;
        pick     = '0;
        pick_idx = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            eligible[i] = valid_q[i] & rs_rdy_q[i] & rt_rdy_q[i]
                        & ~(issue_valid_q && (issue_slot_q == IDX_W'(i)));
        end
        for (int i = 0; i < IQ_SIZE; i++) begin
            pick[i] = eligible[i];
            for (int j = 0; j < IQ_SIZE; j++) begin
                if (j != i && eligible[j] && older_q[j][i]) pick[i] = 1'b0;
            end
        end
        any_elig = |eligible;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d       = valid_q;
        rs_rdy_d      = rs_rdy_q;
        rt_rdy_d      = rt_rdy_q;
        rs_tag_d      = rs_tag_q;
        rt_tag_d      = rt_tag_q;
        older_d       = older_q;
        issue_valid_d = issue_valid_q;
        issue_slot_d  = issue_slot_q;
        occ_d         = occ_q;

        alloc_fire = alloc_valid && alloc_ready && !flush;
        issue_fire = issue_valid_q && issue_ready;
        can_load   = !issue_valid_q || issue_ready;

        for (int i = 0; i < IQ_SIZE; i++) begin
            if (wb_valid && valid_q[i]) begin
                if (rs_tag_q[i] == wb_tag) rs_rdy_d[i] = 1'b1;
                if (rt_tag_q[i] == wb_tag) rt_rdy_d[i] = 1'b1;
            end
        end

        if (issue_fire) valid_d[issue_slot_q] = 1'b0;

        if (alloc_fire) begin
            valid_d[alloc_slot]  = 1'b1;
            rs_tag_d[alloc_slot] = alloc_rs;
            rt_tag_d[alloc_slot] = alloc_rt;
            // writeback landing in the allocation cycle must not be missed
            rs_rdy_d[alloc_slot] = !alloc_uses_rs || alloc_rs_rdy || (wb_valid && wb_tag == alloc_rs);
            rt_rdy_d[alloc_slot] = !alloc_uses_rt || alloc_rt_rdy || (wb_valid && wb_tag == alloc_rt);
            for (int j = 0; j < IQ_SIZE; j++) begin
                older_d[alloc_slot][j] = 1'b0;
                older_d[j][alloc_slot] = 1'b1;
            end
            older_d[alloc_slot][alloc_slot] = 1'b0;
        end

        if (can_load) begin
            issue_valid_d = any_elig;
            if (any_elig) issue_slot_d = pick_idx;
        end

        case ({alloc_fire, issue_fire})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (flush) begin
            valid_d       = '0;
            issue_valid_d = 1'b0;
            occ_d         = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            rs_rdy_q      <= '0;
            rt_rdy_q      <= '0;
            rs_tag_q      <= '0;
            rt_tag_q      <= '0;
            older_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_slot_q  <= '0;
            occ_q         <= '0;
        end else begin
            valid_q       <= valid_d;
            rs_rdy_q      <= rs_rdy_d;
            rt_rdy_q      <= rt_rdy_d;
            rs_tag_q      <= rs_tag_d;
            rt_tag_q      <= rt_tag_d;
            older_q       <= older_d;
            issue_valid_q <= issue_valid_d;
            issue_slot_q  <= issue_slot_d;
            occ_q         <= occ_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_slot  = issue_slot_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: sequence-number reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_issue_scheduler;
    localparam int IQ = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          alloc_valid = 1'b0;
    logic [PW-1:0] alloc_rs = '0, alloc_rt = '0;
    logic          alloc_uses_rs = 1'b0, alloc_uses_rt = 1'b0;
    logic          alloc_rs_rdy = 1'b0, alloc_rt_rdy = 1'b0;
    logic          alloc_ready;
    logic [2:0]    alloc_slot;
    logic          wb_valid = 1'b0;
    logic [PW-1:0] wb_tag = '0;
    logic          issue_valid;
    logic [2:0]    issue_slot;
    logic          issue_ready = 1'b0;
    logic [3:0]    occupancy;

    int checks = 0;
    int errors = 0;

    // reference model: per-slot record plus allocation sequence number for age
    bit m_v[IQ], m_rsr[IQ], m_rtr[IQ];
    int m_rs[IQ], m_rt[IQ], m_age[IQ];
    int seq;
    bit m_iv;
    int m_is, m_occ;

    issue_scheduler #(.IQ_SIZE(IQ), .PHYS_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rs(alloc_rs), .alloc_rt(alloc_rt),
        .alloc_uses_rs(alloc_uses_rs), .alloc_uses_rt(alloc_uses_rt),
        .alloc_rs_rdy(alloc_rs_rdy), .alloc_rt_rdy(alloc_rt_rdy),
        .alloc_ready(alloc_ready), .alloc_slot(alloc_slot),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(issue_valid), .issue_slot(issue_slot),
        .issue_ready(issue_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < IQ; i++) begin
            m_v[i] = 0; m_rsr[i] = 0; m_rtr[i] = 0;
        end
        m_iv = 0; m_is = 0; m_occ = 0; seq = 0;
    endtask

    function automatic int first_free();
        for (int i = 0; i < IQ; i++) if (!m_v[i]) return i;
        return -1;
    endfunction

    task automatic compare();
        int f;
        f = first_free();
        chk("alloc_ready", alloc_ready, (f >= 0));
        if (f >= 0) chk("alloc_slot", alloc_slot, f);
        chk("issue_valid", issue_valid, m_iv);
        if (m_iv) chk("issue_slot", issue_slot, m_is);
        chk("occupancy", occupancy, m_occ);
    endtask

    task automatic model_step();
        int best, a;
        bit fire, canl;
        if (flush) begin
            for (int i = 0; i < IQ; i++) m_v[i] = 0;
            m_iv = 0; m_occ = 0;
            return;
        end
        fire = m_iv && issue_ready;
        canl = !m_iv || issue_ready;
        best = -1;
        for (int i = 0; i < IQ; i++)
            if (m_v[i] && m_rsr[i] && m_rtr[i] && !(m_iv && m_is == i))
                if (best < 0 || m_age[i] < m_age[best]) best = i;
        a = first_free();
        if (wb_valid)
            for (int i = 0; i < IQ; i++)
                if (m_v[i]) begin
                    if (m_rs[i] == int'(wb_tag)) m_rsr[i] = 1;
                    if (m_rt[i] == int'(wb_tag)) m_rtr[i] = 1;
                end
        if (fire) begin m_v[m_is] = 0; m_occ--; end
        if (alloc_valid && a >= 0) begin
            m_v[a] = 1; m_rs[a] = alloc_rs; m_rt[a] = alloc_rt;
            m_rsr[a] = !alloc_uses_rs || alloc_rs_rdy || (wb_valid && wb_tag == alloc_rs);
            m_rtr[a] = !alloc_uses_rt || alloc_rt_rdy || (wb_valid && wb_tag == alloc_rt);
            m_age[a] = seq++; m_occ++;
        end
        if (canl) begin
            m_iv = (best >= 0);
            if (best >= 0) m_is = best;
        end
    endtask

    // entered at posedge+1 with inputs applied; leaves at next posedge+1
    task automatic tick();
        #2;
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_slot", alloc_slot, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_slot", issue_slot, 0);
        chk("rst_occupancy", occupancy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle();
        alloc_valid = 0; wb_valid = 0; flush = 0;
    endtask

    task automatic set_alloc(input int rs, input int rt, input bit urs, input bit urt,
                             input bit rrs, input bit rrt);
        alloc_valid = 1; alloc_rs = PW'(rs); alloc_rt = PW'(rt);
        alloc_uses_rs = urs; alloc_uses_rt = urt;
        alloc_rs_rdy = rrs; alloc_rt_rdy = rrt;
    endtask

    initial begin
        do_reset();

        // three ready instructions issue in order
        issue_ready = 1;
        set_alloc(0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("r35_slot0", issue_slot, 0);
        tick();
        chk("r35_slot1", issue_slot, 1);
        idle();
        tick();
        chk("r35_slot2", issue_slot, 2);
        tick();
        chk("r35_empty_iv", issue_valid, 0);
        chk("r35_empty_occ", occupancy, 0);

        // unready older slot is bypassed, then woken
        do_reset(); issue_ready = 1;
        set_alloc(5, 0, 1, 0, 0, 0); tick();
        set_alloc(0, 0, 0, 0, 0, 0); tick();
        idle(); tick();
        chk("r36_first", issue_slot, 1);
        wb_valid = 1; wb_tag = 5; tick();
        wb_valid = 0; tick();
        chk("r36_woken_iv", issue_valid, 1);
        chk("r36_woken_slot", issue_slot, 0);
        tick();

        // full queue, then a freed middle slot is reused
        do_reset(); issue_ready = 0;
        for (int i = 0; i < IQ; i++) begin
            set_alloc(20, 0, 1, 0, (i == 3), 0);
            tick();
        end
        chk("r37_full", alloc_ready, 0);
        chk("r37_held3", issue_slot, 3);
        set_alloc(1, 1, 0, 0, 1, 1); tick();
        chk("r37_ninth_occ", occupancy, 8);
        idle(); issue_ready = 1; tick();
        chk("r37_reuse", alloc_slot, 3);
        chk("r37_occ", occupancy, 7);

        // stall holds the issue register
        do_reset(); issue_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_alloc(30, 0, 1, 0, (i >= 2), 0);
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("r38_stable", issue_slot, 2);
            chk("r38_occ", occupancy, 4);
            tick();
        end
        issue_ready = 1; tick();
        chk("r38_next", issue_slot, 3);
        chk("r38_occ_after", occupancy, 3);

        // allocation and matching writeback in the same cycle
        do_reset(); issue_ready = 1;
        set_alloc(9, 0, 1, 0, 0, 0); wb_valid = 1; wb_tag = 9; tick();
        idle(); tick();
        chk("r39_iv", issue_valid, 1);
        chk("r39_slot", issue_slot, 0);
        tick();

        // flush beats a concurrent allocation
        do_reset(); issue_ready = 0;
        for (int i = 0; i < 5; i++) begin set_alloc(0, 0, 0, 0, 1, 1); tick(); end
        chk("r40_pre_iv", issue_valid, 1);
        chk("r40_pre_occ", occupancy, 5);
        flush = 1; tick();
        idle();
        chk("r40_iv", issue_valid, 0);
        chk("r40_occ", occupancy, 0);
        chk("r40_slot", alloc_slot, 0);

        // reset in the middle of a stall
        for (int i = 0; i < 3; i++) begin set_alloc(0, 0, 0, 0, 1, 1); tick(); end
        do_reset();
        set_alloc(0, 0, 0, 0, 1, 1); tick();
        idle();
        chk("r34_occ", occupancy, 1);
        chk("r34_next_slot", alloc_slot, 1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            alloc_valid   = ($urandom_range(0, 9) < 6);
            alloc_rs      = PW'($urandom_range(0, 7));
            alloc_rt      = PW'($urandom_range(0, 7));
            alloc_uses_rs = $urandom_range(0, 1);
            alloc_uses_rt = $urandom_range(0, 1);
            alloc_rs_rdy  = ($urandom_range(0, 2) == 0);
            alloc_rt_rdy  = ($urandom_range(0, 2) == 0);
            wb_valid      = $urandom_range(0, 1);
            wb_tag        = PW'($urandom_range(0, 7));
            issue_ready   = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 149) == 0);
            tick();
            if (c % 700 == 699) do_reset();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
